// File: rtl/span_fill_pkg.sv
// Shared graphics definitions for the span filler: screen geometry defaults,
// address width and the fill FSM state encoding.
package span_fill_pkg;

  localparam int unsigned SCREEN_W_DEF = 640;
  localparam int unsigned SCREEN_H_DEF = 480;
  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned X_W          = 11;
  localparam int unsigned Y_W          = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRITE,
    ST_FINISH
  } state_t;

  // y * w built from shifted copies of y, one per set bit of the constant w,
  // so synthesis produces a fixed adder tree rather than a multiplier.
  function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y,
                                                 input int unsigned     w);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (((w >> i) & 32'd1) != 32'd0) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/span_fill_addr_gen.sv
// Span address generator: clamps the span end to the screen and forms the
// linear framebuffer address row_base(y) + x.
module span_addr_gen
  import span_fill_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF
) (
  input  logic [Y_W-1:0]    y_i,
  input  logic [X_W-1:0]    x_i,
  input  logic [X_W-1:0]    end_i,
  output logic [X_W-1:0]    end_clamp_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);

  always_comb begin
    end_clamp_o = (end_i > X_MAX) ? X_MAX : end_i;
    addr_o      = row_base(y_i, SCREEN_W) + ADDR_W'(x_i);
  end

endmodule

// File: rtl/span_fill.sv
// Horizontal span filler: latches a span request and writes one pixel per
// accepted framebuffer handshake, pulsing done when the span is complete.
module span_fill
  import span_fill_pkg::*;
#(
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned COLOR_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               draw,
  input  logic [10:0]        start_x,
  input  logic [10:0]        end_x,
  input  logic [9:0]         y_coord,
  input  logic [COLOR_W-1:0] color,
  input  logic               fb_ready,
  output logic               fb_we,
  output logic [18:0]        fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic               done
);

  state_t               state_q, state_d;
  logic [X_W-1:0]       sx_q, sx_d;
  logic [X_W-1:0]       ex_q, ex_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   col_q, col_d;
  logic [X_W-1:0]       x_q, x_d;

  logic [X_W-1:0]       end_clamp;
  logic [ADDR_W-1:0]    pix_addr;
  logic                 span_empty;

  span_addr_gen #(.SCREEN_W(SCREEN_W)) u_addr_gen (
    .y_i         (y_q),
    .x_i         (x_q),
    .end_i       (ex_q),
    .end_clamp_o (end_clamp),
    .addr_o      (pix_addr)
  );

  assign span_empty = (32'(y_q) >= SCREEN_H) || (32'(sx_q) >= SCREEN_W) ||
                      (sx_q > end_clamp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sx_q    <= '0;
      ex_q    <= '0;
      y_q     <= '0;
      col_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      ex_q    <= ex_d;
      y_q     <= y_d;
      col_q   <= col_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    ex_d    = ex_q;
    y_d     = y_q;
    col_d   = col_q;
    x_d     = x_q;
    case (state_q)
      ST_IDLE: begin
        if (draw) begin
          sx_d    = start_x;
          ex_d    = end_x;
          y_d     = y_coord;
          col_d   = color;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (span_empty) begin
          state_d = ST_FINISH;
        end else begin
          x_d     = sx_q;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (fb_ready) begin
          if (x_q == end_clamp) state_d = ST_FINISH;
          else                  x_d     = x_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from the state register alone, so the asynchronous reset
  // zeroes them in the same instant it forces IDLE.
  always_comb begin
    fb_we   = (state_q == ST_WRITE);
    fb_addr = fb_we ? pix_addr : '0;
    fb_data = fb_we ? col_q : '0;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_FINISH);
  end

endmodule

// File: tb/tb_span_fill.sv
// Self-checking bench for span_fill: expected pixel writes are queued when a
// span is requested and popped as the framebuffer handshake completes.
module tb_span_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic        draw;
  logic [10:0] start_x, end_x;
  logic [9:0]  y_coord;
  logic [7:0]  color;
  logic        fb_ready;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        busy, done;

  typedef struct {
    logic [18:0] a;
    logic [7:0]  d;
    int          k;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  span_fill #(.SCREEN_W(640), .SCREEN_H(480), .COLOR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .draw     (draw),
    .start_x  (start_x),
    .end_x    (end_x),
    .y_coord  (y_coord),
    .color    (color),
    .fb_ready (fb_ready),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic drive_draw(input int sx, input int ex, input int y, input int col);
    @(posedge clk);
    #1;
    draw    = 1'b1;
    start_x = 11'(sx);
    end_x   = 11'(ex);
    y_coord = 10'(y);
    color   = 8'(col);
  endtask

  // Model of the expected writes; returns the number of pixels pushed.
  task automatic push_span(input int sx, input int ex, input int y, input int col,
                           input int first_k, output int n);
    int ec;
    exp_t e;
    ec = (ex > 639) ? 639 : ex;
    n  = 0;
    if (y < 480 && sx < 640 && sx <= ec) begin
      for (int x = sx; x <= ec; x++) begin
        e.a = 19'(y * 640 + x);
        e.d = 8'(col);
        e.k = first_k + n;
        exp_q.push_back(e);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    draw     = 1'b0;
    start_x  = '0;
    end_x    = '0;
    y_coord  = '0;
    color    = '0;
    fb_ready = 1'b1;
    #3;
    compared++;
    if ({fb_we, fb_addr, fb_data, busy, done} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got we=%b addr=%0d data=%h busy=%b done=%b, required all zero",
               fb_we, fb_addr, fb_data, busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Table of spans issued back to back: each draw lands in the cycle right
  // after the previous done pulse.
  task automatic test_spans();
    int sx_t[7]  = '{10, 639, 630, 20, 5, 700, 0};
    int ex_t[7]  = '{13, 639, 700, 5, 9, 710, 0};
    int y_t[7]   = '{2, 479, 0, 7, 480, 1, 0};
    int col_t[7] = '{8'h5A, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    int n;
    bit got_done;
    exp_t e;
    for (int c = 0; c < 7; c++) begin
      drive_draw(sx_t[c], ex_t[c], y_t[c], col_t[c]);
      push_span(sx_t[c], ex_t[c], y_t[c], col_t[c], 2, n);
      got_done = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (k == 0) begin
          compared++;
          if (busy !== 1'b0 || fb_we !== 1'b0) begin
            mismatched++;
            $display("FAIL case%0d_idle_at_draw: busy=%b we=%b, required 0 0", c, busy, fb_we);
          end
        end
        if (k == 1) begin
          compared++;
          if (busy !== 1'b1 || fb_we !== 1'b0) begin
            mismatched++;
            $display("FAIL case%0d_setup: busy=%b we=%b, required 1 0", c, busy, fb_we);
          end
        end
        if (fb_we === 1'b1 && fb_ready === 1'b1) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL case%0d_extra_write: addr=%0d at cycle %0d, required no write", c, fb_addr, k);
          end else begin
            e = exp_q.pop_front();
            if (fb_addr !== e.a || fb_data !== e.d || k != e.k) begin
              mismatched++;
              $display("FAIL case%0d_write: addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                       c, fb_addr, fb_data, k, e.a, e.d, e.k);
            end
          end
        end
        if (done === 1'b1) begin
          compared++;
          if (k != n + 2) begin
            mismatched++;
            $display("FAIL case%0d_done_cycle: done at %0d, required %0d", c, k, n + 2);
          end
          got_done = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
        draw = 1'b0;
      end
      compared++;
      if (!got_done || exp_q.size() != 0) begin
        mismatched++;
        $display("FAIL case%0d_complete: done_seen=%0d writes_missing=%0d, required 1 and 0",
                 c, got_done, exp_q.size());
      end
      exp_q.delete();
    end
  endtask

  // Span 0..3 with a three-cycle stall on the second pixel; extra draws are
  // issued mid-span and during the done cycle and must both be ignored.
  task automatic test_stall();
    int   n, writes, dones;
    exp_t e;
    exp_t stalled[$];
    drive_draw(0, 3, 0, 8'hA7);
    push_span(0, 3, 0, 8'hA7, 2, n);
    e.a = 19'd1; e.d = 8'hA7; e.k = 6;
    stalled.push_back(e);
    exp_q[1] = e;
    exp_q[2].k = 7;
    exp_q[3].k = 8;
    writes = 0;
    dones  = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 5) begin
        compared++;
        if (fb_we !== 1'b1 || fb_addr !== 19'd1 || fb_data !== 8'hA7) begin
          mismatched++;
          $display("FAIL stall_hold k=%0d: we=%b addr=%0d data=%h, required 1 1 a7",
                   k, fb_we, fb_addr, fb_data);
        end
      end
      if (fb_we === 1'b1 && fb_ready === 1'b1) begin
        writes++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL stall_extra_write: addr=%0d at cycle %0d, required no write", fb_addr, k);
        end else begin
          e = exp_q.pop_front();
          if (fb_addr !== e.a || fb_data !== e.d || k != e.k) begin
            mismatched++;
            $display("FAIL stall_write: addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                     fb_addr, fb_data, k, e.a, e.d, e.k);
          end
        end
      end
      if (done === 1'b1) begin
        dones++;
        compared++;
        if (k != 9) begin
          mismatched++;
          $display("FAIL stall_done_cycle: done at %0d, required 9", k);
        end
      end
      @(posedge clk);
      #1;
      draw     = (k + 1 == 4 || k + 1 == 9);
      start_x  = 11'd100;
      end_x    = 11'd120;
      y_coord  = 10'd5;
      color    = 8'h0F;
      fb_ready = !(k + 1 >= 3 && k + 1 <= 5);
    end
    draw     = 1'b0;
    fb_ready = 1'b1;
    compared++;
    if (writes != 4 || dones != 1 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL stall_totals: writes=%0d dones=%0d missing=%0d, required 4 1 0",
               writes, dones, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int   n, stray;
    bit   got_done;
    exp_t e;
    drive_draw(0, 9, 3, 8'h77);
    push_span(0, 9, 3, 8'h77, 2, n);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (fb_we === 1'b1 && fb_ready === 1'b1) begin
        compared++;
        e = exp_q.pop_front();
        if (fb_addr !== e.a || fb_data !== e.d || k != e.k) begin
          mismatched++;
          $display("FAIL rstmid_write: addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                   fb_addr, fb_data, k, e.a, e.d, e.k);
        end
      end
      @(posedge clk);
      #1;
      draw = 1'b0;
    end
    // Now one nanosecond into cycle 4, with the third pixel on the bus.
    compared++;
    if (fb_we !== 1'b1 || fb_addr !== 19'd1922) begin
      mismatched++;
      $display("FAIL rstmid_third_write: we=%b addr=%0d, required 1 1922", fb_we, fb_addr);
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({fb_we, fb_addr, fb_data, busy, done} !== '0) begin
      mismatched++;
      $display("FAIL rstmid_immediate: we=%b addr=%0d data=%h busy=%b done=%b, required all zero",
               fb_we, fb_addr, fb_data, busy, done);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    stray = 0;
    repeat (15) begin
      @(negedge clk);
      if (fb_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray++;
    end
    compared++;
    if (stray != 0) begin
      mismatched++;
      $display("FAIL rstmid_quiet: %0d active cycles after reset, required 0", stray);
    end
    drive_draw(5, 6, 1, 8'h99);
    push_span(5, 6, 1, 8'h99, 2, n);
    got_done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (fb_we === 1'b1 && fb_ready === 1'b1) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rstmid_new_extra: addr=%0d at cycle %0d, required no write", fb_addr, k);
        end else begin
          e = exp_q.pop_front();
          if (fb_addr !== e.a || fb_data !== e.d || k != e.k) begin
            mismatched++;
            $display("FAIL rstmid_new_write: addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                     fb_addr, fb_data, k, e.a, e.d, e.k);
          end
        end
      end
      if (done === 1'b1) begin
        compared++;
        if (k != n + 2) begin
          mismatched++;
          $display("FAIL rstmid_new_done: done at %0d, required %0d", k, n + 2);
        end
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      draw = 1'b0;
    end
    compared++;
    if (!got_done || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL rstmid_new_complete: done_seen=%0d missing=%0d, required 1 0",
               got_done, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_spans();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/span_fill.md
SPAN_FILL -- requirements
Module: span_fill

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, visible pixels per line.
REQ-002 SHALL have parameter SCREEN_H, default 480, visible lines.
REQ-003 SHALL have parameter COLOR_W, default 8, pixel colour width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port draw, input, 1, one-cycle span request pulse.
REQ-007 SHALL have port start_x, input, 11, first pixel column, inclusive.
REQ-008 SHALL have port end_x, input, 11, last pixel column, inclusive.
REQ-009 SHALL have port y_coord, input, 10, span row.
REQ-010 SHALL have port color, input, COLOR_W, fill colour.
REQ-011 SHALL have port fb_ready, input, 1, framebuffer accepts the current write.
REQ-012 SHALL have port fb_we, output, 1, framebuffer write request.
REQ-013 SHALL have port fb_addr, output, 19, linear pixel address.
REQ-014 SHALL have port fb_data, output, COLOR_W, pixel colour.
REQ-015 SHALL have port busy, output, 1, span in progress.
REQ-016 SHALL have port done, output, 1, one-cycle span-complete pulse (drives the line stage's bresenham_done).

Function
REQ-017 SHALL implement states IDLE, SETUP, WRITE, FINISH.
REQ-018 IDLE: on draw=1, SHALL latch start_x, end_x, y_coord, color, set busy=1 and go to SETUP; otherwise remain in IDLE.
REQ-019 SHALL ignore draw whenever state is not IDLE; latched operands stay unchanged.
REQ-020 SETUP SHALL clamp end to min(end_x, SCREEN_W-1) and compute row base = y*SCREEN_W using shifts/adds only (y<<9 + y<<7 for 640), no multiplier.
REQ-021 SETUP SHALL go to FINISH with no writes if y >= SCREEN_H, start_x >= SCREEN_W, or start_x > clamped end; otherwise go to WRITE with x = start_x.
REQ-022 WRITE SHALL assert fb_we=1, fb_addr = base + x, fb_data = latched colour, holding all three stable until fb_ready=1.
REQ-023 A write SHALL complete on a cycle where fb_we=1 and fb_ready=1; then x increments by 1, or, if x equals clamped end, state goes to FINISH with fb_we=0 next cycle.
REQ-024 fb_ready while fb_we=0 SHALL have no effect.
REQ-025 FINISH SHALL pulse done=1 for exactly one cycle, clear busy, and return to IDLE; a draw in that cycle is ignored.
REQ-026 Latency with fb_ready tied high: draw at cycle 0, first fb_we at cycle 2, N pixels written in cycles 2..N+1, done at cycle N+2, next draw accepted at cycle N+3.
REQ-027 Span is inclusive: start_x == end_x writes exactly one pixel.
REQ-028 fb_addr SHALL never exceed SCREEN_W*SCREEN_H-1.

Reset
REQ-029 reset=1 SHALL immediately force state IDLE, fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0, regardless of state.
REQ-030 Reset mid-WRITE SHALL abort the span; no done pulse is produced for it and no write is issued after reset deasserts until a new draw.

Structure
REQ-031 SCREEN_W/SCREEN_H defaults, the 19-bit address width and the state enum SHALL live in the shared graphics package.
REQ-032 The address generator (row base + x, clamp) SHALL be one sub-module, span_addr_gen; the FSM and handshake stay in span_fill.

Verification
REQ-033 draw, start_x=10, end_x=13, y=2, color=0x5A, fb_ready=1 -> addresses 1290,1291,1292,1293 with data 0x5A on cycles 2-5, done at cycle 6.
REQ-034 start_x=end_x=639, y=479 -> single write at address 307199, done at cycle 3.
REQ-035 start_x=630, end_x=700, y=0 -> writes 630..639 only (10 writes), done follows last write.
REQ-036 start_x=20, end_x=5 or y=480 -> zero writes, done at cycle 2.
REQ-037 span 0..3, fb_ready low for 3 cycles on second pixel -> fb_addr=1 and fb_data held stable, fb_we=1 throughout; exactly 4 writes total; second draw during busy ignored.
REQ-038 reset asserted during third write of a 10-pixel span -> outputs zero immediately, no done pulse; next draw starts a clean span.
